feature_vector_loader: RTL and testbench

FEATURE_VECTOR_LOADER -- requirements
Module: feature_vector_loader

---
 rtl/feature_vector_loader.sv | 111 +++++++++++
 tb/tb_feature_vector_loader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/feature_vector_loader.sv
// Double-buffered int8 feature-vector assembler: streams elements into a fill buffer, swaps to a stable output buffer.
// Optional framing check against s_last is enabled by defining FRAME_CHECK_EN.
module feature_vector_loader #(
   parameter int VEC_LEN = 16,
   parameter int DATA_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic signed [DATA_W-1:0] s_data,
   input  logic                     s_last,
   output logic signed [DATA_W-1:0] vec_out [0:VEC_LEN-1],
   output logic                     vec_valid,
   input  logic                     vec_ack,
   output logic                     frame_err,
   output logic [7:0]               err_cnt
);

   localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(VEC_LEN - 1);

   typedef enum logic {FILL, HOLD} state_t;

   state_t                    state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic signed [DATA_W-1:0]  fill_q [0:VEC_LEN-1];
   logic signed [DATA_W-1:0]  fill_d [0:VEC_LEN-1];
   logic signed [DATA_W-1:0]  out_q  [0:VEC_LEN-1];
   logic signed [DATA_W-1:0]  out_d  [0:VEC_LEN-1];
   logic                      vld_q, vld_d;
   logic                      accept, at_end, bad, complete, swap;

`ifdef FRAME_CHECK_EN
   logic       ferr_q, ferr_d;
   logic [7:0] errcnt_q, errcnt_d;

   assign bad       = accept && (s_last != at_end);
   assign frame_err = ferr_q;
   assign err_cnt   = errcnt_q;
`else
   logic unused_s_last;

   assign unused_s_last = s_last;
   assign bad           = 1'b0;
   assign frame_err     = 1'b0;
   assign err_cnt       = '0;
`endif

   assign s_ready   = (state_q == FILL);
   assign vec_valid = vld_q;
   assign vec_out   = out_q;

   assign accept   = s_valid && (state_q == FILL);
   assign at_end   = (cnt_q == LAST_IDX);
   assign complete = (accept && at_end && !bad) || (state_q == HOLD);
   assign swap     = complete && (!vld_q || vec_ack);

   always_comb begin
      fill_d  = fill_q;
      out_d   = out_q;
      vld_d   = vld_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      if (accept) fill_d[cnt_q] = s_data;
      // The swap copies fill_d so the element accepted on this edge lands in the output too.
      if (swap) out_d = fill_d;
      if (vec_ack) vld_d = 1'b0;
      if (swap) vld_d = 1'b1;
      if (bad) begin
         cnt_d = '0;
      end else if (swap) begin
         cnt_d   = '0;
         state_d = FILL;
      end else if (complete) begin
         state_d = HOLD;
      end else if (accept) begin
         cnt_d = cnt_q + 1'b1;
      end
`ifdef FRAME_CHECK_EN
      ferr_d   = bad;
      errcnt_d = errcnt_q;
      if (bad && (errcnt_q != 8'hFF)) errcnt_d = errcnt_q + 8'd1;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         fill_q  <= '{default: '0};
         out_q   <= '{default: '0};
`ifdef FRAME_CHECK_EN
         ferr_q   <= 1'b0;
         errcnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
         fill_q  <= fill_d;
         out_q   <= out_d;
`ifdef FRAME_CHECK_EN
         ferr_q   <= ferr_d;
         errcnt_q <= errcnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_feature_vector_loader.sv
// Directed self-checking bench for feature_vector_loader (VEC_LEN=16, DATA_W=8).
module tb_feature_vector_loader;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              s_valid;
   logic              s_ready;
   logic signed [7:0] s_data;
   logic              s_last;
   logic signed [7:0] vec_out [0:15];
   logic              vec_valid;
   logic              vec_ack;
   logic              frame_err;
   logic [7:0]        err_cnt;

   int errors = 0;
   int checks = 0;

   feature_vector_loader #(.VEC_LEN(16), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .vec_out(vec_out), .vec_valid(vec_valid),
      .vec_ack(vec_ack), .frame_err(frame_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int d, input bit l);
      int w = 0;
      while (!s_ready && w < 50) begin
         @(posedge clk); #1; w++;
      end
      if (!s_ready) chk("push_ready_timeout", int'(s_ready), 1);
      s_valid = 1'b1; s_data = 8'(d); s_last = l;
      @(posedge clk); #1;
   endtask

   task automatic idle();
      s_valid = 1'b0; s_last = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic ack_pulse();
      s_valid = 1'b0; s_last = 1'b0; vec_ack = 1'b1;
      @(posedge clk); #1;
      vec_ack = 1'b0;
   endtask

   function automatic int pat(input int k);
      if (k % 3 == 0) return -128;
      if (k % 3 == 1) return 127;
      return -1;
   endfunction

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; vec_ack = 1'b0;
      #12;
      chk("rst_vec_valid", int'(vec_valid), 0);
      chk("rst_s_ready", int'(s_ready), 1);
      chk("rst_frame_err", int'(frame_err), 0);
      chk("rst_err_cnt", int'(err_cnt), 0);
      chk("rst_vec_out0", int'(vec_out[0]), 0);
      chk("rst_vec_out15", int'(vec_out[15]), 0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic frame 1..16
      for (int i = 1; i <= 15; i++) push(i, 1'b0);
      chk("basic_not_yet_valid", int'(vec_valid), 0);
      push(16, 1'b1);
      chk("basic_valid", int'(vec_valid), 1);
      chk("basic_out0", int'(vec_out[0]), 1);
      chk("basic_out7", int'(vec_out[7]), 8);
      chk("basic_out15", int'(vec_out[15]), 16);
      chk("basic_ready", int'(s_ready), 1);
      ack_pulse();
      chk("basic_ack_clears", int'(vec_valid), 0);

      // Backpressure: two frames, no ack
      for (int k = 0; k < 16; k++) push(pat(k), k == 15);
      chk("bp_f1_valid", int'(vec_valid), 1);
      for (int k = 16; k < 32; k++) push(pat(k), k == 31);
      chk("bp_ready_low", int'(s_ready), 0);
      chk("bp_f1_out0", int'(vec_out[0]), -128);
      chk("bp_f1_out1", int'(vec_out[1]), 127);
      chk("bp_f1_out2", int'(vec_out[2]), -1);
      s_data = 8'sd55; s_last = 1'b1;
      @(posedge clk); #1;
      chk("bp_hold_ready", int'(s_ready), 0);
      chk("bp_hold_out0", int'(vec_out[0]), -128);
      ack_pulse();
      chk("bp_swap_valid", int'(vec_valid), 1);
      chk("bp_f2_out0", int'(vec_out[0]), 127);
      chk("bp_f2_out2", int'(vec_out[2]), -128);
      chk("bp_f2_out15", int'(vec_out[15]), 127);
      chk("bp_ready_back", int'(s_ready), 1);
      ack_pulse();
      chk("bp_f2_cleared", int'(vec_valid), 0);

      // Ack on the same edge as the next frame's last element
      for (int i = 0; i < 16; i++) push(10 + i, i == 15);
      for (int i = 0; i < 15; i++) push(40 + i, 1'b0);
      chk("coinc_a_out0", int'(vec_out[0]), 10);
      vec_ack = 1'b1;
      push(55, 1'b1);
      vec_ack = 1'b0;
      chk("coinc_valid_stays", int'(vec_valid), 1);
      chk("coinc_b_out0", int'(vec_out[0]), 40);
      chk("coinc_b_out15", int'(vec_out[15]), 55);
      chk("coinc_ready", int'(s_ready), 1);
      ack_pulse();
      chk("coinc_cleared", int'(vec_valid), 0);
      ack_pulse();
      chk("ack_when_idle_ignored", int'(vec_valid), 0);

`ifdef FRAME_CHECK_EN
      // Early s_last on the 5th element
      for (int i = 0; i < 5; i++) push(70 + i, i == 4);
      chk("ferr_pulse", int'(frame_err), 1);
      chk("ferr_cnt", int'(err_cnt), 1);
      chk("ferr_no_valid", int'(vec_valid), 0);
      idle();
      chk("ferr_one_cycle", int'(frame_err), 0);
      for (int i = 0; i < 16; i++) push(-5 - i, i == 15);
      chk("ferr_next_valid", int'(vec_valid), 1);
      chk("ferr_next_out0", int'(vec_out[0]), -5);
      chk("ferr_next_out15", int'(vec_out[15]), -20);
      chk("ferr_cnt_kept", int'(err_cnt), 1);
      ack_pulse();
`else
      // s_last toggled arbitrarily has no effect
      for (int i = 0; i < 16; i++) begin
         push(-60 + i, 1'($urandom_range(1, 0)));
         chk("nochk_frame_err", int'(frame_err), 0);
      end
      chk("nochk_valid", int'(vec_valid), 1);
      chk("nochk_out0", int'(vec_out[0]), -60);
      chk("nochk_out15", int'(vec_out[15]), -45);
      chk("nochk_err_cnt", int'(err_cnt), 0);
      ack_pulse();
`endif

      // Reset mid-frame with a held vector
      for (int i = 0; i < 16; i++) push(20 + i, i == 15);
      for (int i = 0; i < 9; i++) push(1 + i, 1'b0);
      s_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", int'(vec_valid), 0);
      chk("mid_rst_out0", int'(vec_out[0]), 0);
      chk("mid_rst_ready", int'(s_ready), 1);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 15; i++) push(100 + i, 1'b0);
      chk("post_rst_not_early", int'(vec_valid), 0);
      push(115, 1'b1);
      chk("post_rst_valid", int'(vec_valid), 1);
      chk("post_rst_out0", int'(vec_out[0]), 100);
      chk("post_rst_out15", int'(vec_out[15]), 115);
      chk("post_rst_err_cnt", int'(err_cnt), 0);
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
